costas_lock_ctrl: RTL

COSTAS_LOCK_CTRL -- requirements
Module: costas_lock_ctrl

---
 rtl/costas_lock_ctrl.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/costas_lock_ctrl.sv
// costas_lock_ctrl -- lock detector and loop-gain controller for a Costas
// carrier loop.
//
// Accepted I/Q samples feed a per-sample lock metric (BPSK: |I|-|Q|;
// QPSK: |I|+|Q|-2*||I|-|Q||). The metric is summed over 2^WIN_LOG2 samples,
// and each window average drives an ACQ/VERIFY/LOCKED/FADE state machine.
// The state machine selects the loop-filter shift and asks for loop restarts.
//
// Ports
//   clk_32M768      sole clock, rising edge
//   rst_n_32M768    synchronous active-low reset
//   I_data, Q_data  signed 16-bit demodulated samples
//   I_valid,Q_valid a sample is taken only when both are high
//   is_bpsk         1 = BPSK metric, 0 = QPSK; any change restarts acquisition
//   FEEDBACK_SHIFT  loop-filter shift (SHIFT_ACQ / SHIFT_TRK), registered
//   locked          high in LOCKED and FADE
//   lock_state      ACQ=0, VERIFY=1, LOCKED=2, FADE=3
//   metric_avg      signed window average, held between windows
//   metric_valid    one-cycle pulse, 3 cycles after the window's last sample
//   loop_clear      one-cycle restart request for loop filter / NCO
module costas_lock_ctrl #(
  parameter int                 WIN_LOG2    = 10,
  parameter logic signed [17:0] LOCK_TH     = 18'sd8192,
  parameter logic signed [17:0] UNLOCK_TH   = 18'sd4096,
  parameter int                 LOCK_CNT    = 4,
  parameter int                 LOSS_CNT    = 2,
  parameter int                 ACQ_TIMEOUT = 64,
  parameter logic [3:0]         SHIFT_ACQ   = 4'd2,
  parameter logic [3:0]         SHIFT_TRK   = 4'd6
) (
  input  logic               clk_32M768,
  input  logic               rst_n_32M768,
  input  logic signed [15:0] I_data,
  input  logic signed [15:0] Q_data,
  input  logic               I_valid,
  input  logic               Q_valid,
  input  logic               is_bpsk,
  output logic [3:0]         FEEDBACK_SHIFT,
  output logic               locked,
  output logic [1:0]         lock_state,
  output logic signed [17:0] metric_avg,
  output logic               metric_valid,
  output logic               loop_clear
);

  typedef enum logic [1:0] {
    ST_ACQ    = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_FADE   = 2'd3
  } state_t;

  localparam int STAGES = 2;
  localparam int ACC_W  = 18 + WIN_LOG2;
  localparam int CNT_W  = 16;

  // |x| with the single unrepresentable case (-32768) saturated.
  function automatic logic [15:0] sat_abs(input logic signed [15:0] x);
    if (x == 16'sh8000) return 16'h7fff;
    return x[15] ? 16'(-x) : 16'(x);
  endfunction

  state_t                    state, state_nxt;
  logic [CNT_W-1:0]          pass_cnt, fail_cnt, tmo_cnt;
  logic [CNT_W-1:0]          pass_nxt, fail_nxt, tmo_nxt;
  logic                      clear_nxt;

  logic                      bpsk_r;
  logic [STAGES:1]           vld_pipe;
  logic [15:0]               a_s1, b_s1;
  logic signed [17:0]        m_s2, m_nxt;
  logic signed [ACC_W-1:0]   acc, sum_nxt;
  logic [WIN_LOG2-1:0]       smp_cnt;
  logic signed [17:0]        avg_nxt;
  logic                      accept, bpsk_chg, win_end;

  assign accept     = I_valid & Q_valid;
  assign bpsk_chg   = is_bpsk ^ bpsk_r;
  assign lock_state = state;

  // Stage 2 metric; |a|,|b| <= 32767 keeps every term inside 18 bits.
  always_comb begin
    logic signed [17:0] sa, sb, diff, adiff;
    sa    = signed'({2'b00, a_s1});
    sb    = signed'({2'b00, b_s1});
    diff  = sa - sb;
    adiff = diff[17] ? -diff : diff;
    m_nxt = bpsk_r ? diff : (sa + sb - (adiff <<< 1));
  end

  // Stage 3: window sum including the sample currently at the end of the pipe.
  assign sum_nxt = acc + ACC_W'(m_s2);
  assign avg_nxt = sum_nxt[WIN_LOG2 +: 18];
  assign win_end = vld_pipe[STAGES] && (smp_cnt == '1);

  always_comb begin
    logic [CNT_W-1:0] pass_inc, fail_inc, tmo_inc;
    state_nxt = state;
    pass_nxt  = pass_cnt;
    fail_nxt  = fail_cnt;
    tmo_nxt   = tmo_cnt;
    clear_nxt = 1'b0;
    pass_inc  = pass_cnt + 1'b1;
    fail_inc  = fail_cnt + 1'b1;
    tmo_inc   = tmo_cnt + 1'b1;
    if (win_end) begin
      unique case (state)
        ST_ACQ: begin
          if (avg_nxt >= LOCK_TH) begin
            state_nxt = ST_VERIFY;
            pass_nxt  = CNT_W'(1);
          end else if (32'(tmo_inc) >= ACQ_TIMEOUT) begin
            tmo_nxt   = '0;
            clear_nxt = 1'b1;
          end else begin
            tmo_nxt = tmo_inc;
          end
        end
        ST_VERIFY: begin
          // Even with LOCK_CNT=1 the lock takes a second passing window here.
          if (avg_nxt >= LOCK_TH) begin
            pass_nxt = pass_inc;
            if (32'(pass_inc) >= LOCK_CNT) state_nxt = ST_LOCKED;
          end else begin
            state_nxt = ST_ACQ;
            tmo_nxt   = '0;
          end
        end
        ST_LOCKED: begin
          if (avg_nxt < UNLOCK_TH) begin
            state_nxt = ST_FADE;
            fail_nxt  = CNT_W'(1);
          end
        end
        ST_FADE: begin
          if (avg_nxt >= UNLOCK_TH) begin
            state_nxt = ST_LOCKED;
          end else if (32'(fail_inc) >= LOSS_CNT) begin
            state_nxt = ST_ACQ;
            fail_nxt  = fail_inc;
            tmo_nxt   = '0;
            clear_nxt = 1'b1;
          end else begin
            fail_nxt = fail_inc;
          end
        end
        default: state_nxt = ST_ACQ;
      endcase
    end
  end

  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768) begin
      bpsk_r         <= is_bpsk;   // no spurious restart after reset
      vld_pipe       <= '0;
      a_s1           <= '0;
      b_s1           <= '0;
      m_s2           <= '0;
      acc            <= '0;
      smp_cnt        <= '0;
      state          <= ST_ACQ;
      pass_cnt       <= '0;
      fail_cnt       <= '0;
      tmo_cnt        <= '0;
      FEEDBACK_SHIFT <= SHIFT_ACQ;
      locked         <= 1'b0;
      metric_avg     <= '0;
      metric_valid   <= 1'b0;
      loop_clear     <= 1'b0;
    end else begin
      bpsk_r       <= is_bpsk;
      a_s1         <= sat_abs(I_data);
      b_s1         <= sat_abs(Q_data);
      m_s2         <= m_nxt;
      metric_valid <= 1'b0;
      loop_clear   <= 1'b0;
      if (bpsk_chg) begin
        // Mode change wins over everything, including a window ending now:
        // flush the pipe and partial sum, restart acquisition.
        vld_pipe       <= '0;
        acc            <= '0;
        smp_cnt        <= '0;
        state          <= ST_ACQ;
        pass_cnt       <= '0;
        fail_cnt       <= '0;
        tmo_cnt        <= '0;
        FEEDBACK_SHIFT <= SHIFT_ACQ;
        locked         <= 1'b0;
        loop_clear     <= 1'b1;
      end else begin
        vld_pipe <= {vld_pipe[STAGES-1], accept};
        if (vld_pipe[STAGES]) begin
          smp_cnt <= smp_cnt + 1'b1;
          acc     <= win_end ? '0 : sum_nxt;
        end
        if (win_end) begin
          metric_avg     <= avg_nxt;
          metric_valid   <= 1'b1;
          state          <= state_nxt;
          pass_cnt       <= pass_nxt;
          fail_cnt       <= fail_nxt;
          tmo_cnt        <= tmo_nxt;
          loop_clear     <= clear_nxt;
          FEEDBACK_SHIFT <= (state_nxt inside {ST_LOCKED, ST_FADE}) ? SHIFT_TRK : SHIFT_ACQ;
          locked         <= (state_nxt inside {ST_LOCKED, ST_FADE});
        end
      end
    end
  end

endmodule
